// File: rtl/dmac_arb_pkg.sv
// Shared types and default sizes for the DMA controller control-port arbiter.
// Optional build macro: DMAC_ARB_FC_PRIO_EN (FC requester at fixed top priority).
package dmac_arb_pkg;

    localparam int NB_REQ_DEF      = 10;
    localparam int ID_W            = $clog2(NB_REQ_DEF);
    localparam int MAX_OUTSTND_DEF = 4;

    typedef logic [ID_W-1:0] req_idx_t;
    typedef logic [$clog2(MAX_OUTSTND_DEF):0] fifo_cnt_t;

    localparam req_idx_t FC_IDX = req_idx_t'(NB_REQ_DEF - 1);
    localparam req_idx_t CL_IDX = req_idx_t'(NB_REQ_DEF - 2);

endpackage

// File: rtl/dmac_arb_id_fifo.sv
// Outstanding-transaction FIFO holding the requester index of each granted command.
// Responses arrive in order, so the head always names the requester to answer.
module dmac_arb_id_fifo
    import dmac_arb_pkg::*;
#(
    parameter int DEPTH = MAX_OUTSTND_DEF,
    parameter int WIDTH = ID_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (PW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) begin
                cnt <= cnt + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmac_ctrl_arbiter.sv
// Round-robin arbiter sharing the mchan control target port among NB_REQ requesters.
// Build macro DMAC_ARB_FC_PRIO_EN gives requester NB_REQ-1 (FC) fixed top priority.
module dmac_ctrl_arbiter
    import dmac_arb_pkg::*;
#(
    parameter int NB_REQ      = NB_REQ_DEF,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BE_WIDTH    = DATA_WIDTH / 8,
    parameter int MAX_OUTSTND = MAX_OUTSTND_DEF,
    parameter int ID_WIDTH    = $clog2(NB_REQ)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NB_REQ-1:0]            req_i,
    input  logic [NB_REQ*ADDR_WIDTH-1:0] add_i,
    input  logic [NB_REQ-1:0]            wen_i,
    input  logic [NB_REQ*DATA_WIDTH-1:0] wdata_i,
    input  logic [NB_REQ*BE_WIDTH-1:0]   be_i,
    output logic [NB_REQ-1:0]            gnt_o,
    output logic [NB_REQ-1:0]            r_valid_o,
    output logic [DATA_WIDTH-1:0]        r_rdata_o,
    output logic                         r_opc_o,
    output logic                         tgt_req_o,
    output logic [ADDR_WIDTH-1:0]        tgt_add_o,
    output logic                         tgt_wen_o,
    output logic [DATA_WIDTH-1:0]        tgt_wdata_o,
    output logic [BE_WIDTH-1:0]          tgt_be_o,
    output logic [ID_WIDTH-1:0]          tgt_id_o,
    input  logic                         tgt_gnt_i,
    input  logic                         tgt_r_valid_i,
    input  logic [DATA_WIDTH-1:0]        tgt_r_rdata_i,
    input  logic                         tgt_r_opc_i,
    output logic                         busy_o,
    output logic                         resp_err_o
);

    localparam int FC = NB_REQ - 1;

    logic [ID_WIDTH-1:0] rr_ptr;
    logic [ID_WIDTH-1:0] win;
    logic [ID_WIDTH-1:0] head;
    logic                any_req;
    logic                fc_win;
    logic                fifo_full;
    logic                fifo_empty;
    logic                hs;
    logic                pop;

`ifdef DMAC_ARB_FC_PRIO_EN
    assign fc_win = req_i[FC];
`else
    assign fc_win = 1'b0;
`endif

    // Search upward from the pointer, wrapping modulo NB_REQ.
    always_comb begin : arb
        int   j;
        logic done;
        win  = '0;
        done = 1'b0;
        j    = 0;
        if (fc_win) begin
            win  = ID_WIDTH'(FC);
            done = 1'b1;
        end
        for (int i = 0; i < NB_REQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NB_REQ) j = j - NB_REQ;
            if (!done && req_i[j[ID_WIDTH-1:0]]) begin
                win  = ID_WIDTH'(j);
                done = 1'b1;
            end
        end
    end

    assign any_req   = |req_i;
    assign tgt_req_o = any_req & ~fifo_full & ~rst_i;
    assign hs        = tgt_req_o & tgt_gnt_i;
    assign tgt_id_o  = win;

    always_comb begin
        tgt_add_o   = '0;
        tgt_wen_o   = 1'b0;
        tgt_wdata_o = '0;
        tgt_be_o    = '0;
        gnt_o       = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            if (any_req && win == ID_WIDTH'(i)) begin
                tgt_add_o   = add_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                tgt_wen_o   = wen_i[i];
                tgt_wdata_o = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                tgt_be_o    = be_i[i*BE_WIDTH +: BE_WIDTH];
            end
        end
        if (hs) gnt_o[win] = 1'b1;
    end

    assign pop       = tgt_r_valid_i & ~fifo_empty;
    assign r_rdata_o = tgt_r_valid_i ? tgt_r_rdata_i : '0;
    assign r_opc_o   = tgt_r_valid_i & tgt_r_opc_i;
    assign busy_o    = ~fifo_empty;

    always_comb begin
        r_valid_o = '0;
        if (pop) r_valid_o[head] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr     <= '0;
            resp_err_o <= 1'b0;
        end else begin
            if (hs && !fc_win) begin
                rr_ptr <= (win == ID_WIDTH'(NB_REQ - 1)) ? '0 : win + 1'b1;
            end
            if (tgt_r_valid_i && fifo_empty) resp_err_o <= 1'b1;
        end
    end

    dmac_arb_id_fifo #(
        .DEPTH (MAX_OUTSTND),
        .WIDTH (ID_WIDTH)
    ) u_id_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (hs),
        .pop   (pop),
        .din   (win),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

endmodule

// File: tb/tb_dmac_ctrl_arbiter.sv
// Self-checking bench for dmac_ctrl_arbiter: model of RR pointer plus an ID scoreboard.
module tb_dmac_ctrl_arbiter;
    import dmac_arb_pkg::*;

    localparam int NB = 10;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int IW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NB-1:0]    req;
    logic [NB*AW-1:0] add;
    logic [NB-1:0]    wen;
    logic [NB*DW-1:0] wdata;
    logic [NB*BW-1:0] be;
    logic [NB-1:0]    gnt;
    logic [NB-1:0]    r_valid;
    logic [DW-1:0]    r_rdata;
    logic             r_opc;
    logic             tgt_req;
    logic [AW-1:0]    tgt_add;
    logic             tgt_wen;
    logic [DW-1:0]    tgt_wdata;
    logic [BW-1:0]    tgt_be;
    logic [IW-1:0]    tgt_id;
    logic             tgt_gnt;
    logic             tgt_r_valid;
    logic [DW-1:0]    tgt_r_rdata;
    logic             tgt_r_opc;
    logic             busy;
    logic             resp_err;

    int pass_cnt = 0;
    int total    = 0;
    int m_ptr    = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    dmac_ctrl_arbiter dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .add_i         (add),
        .wen_i         (wen),
        .wdata_i       (wdata),
        .be_i          (be),
        .gnt_o         (gnt),
        .r_valid_o     (r_valid),
        .r_rdata_o     (r_rdata),
        .r_opc_o       (r_opc),
        .tgt_req_o     (tgt_req),
        .tgt_add_o     (tgt_add),
        .tgt_wen_o     (tgt_wen),
        .tgt_wdata_o   (tgt_wdata),
        .tgt_be_o      (tgt_be),
        .tgt_id_o      (tgt_id),
        .tgt_gnt_i     (tgt_gnt),
        .tgt_r_valid_i (tgt_r_valid),
        .tgt_r_rdata_i (tgt_r_rdata),
        .tgt_r_opc_i   (tgt_r_opc),
        .busy_o        (busy),
        .resp_err_o    (resp_err)
    );

    function automatic logic [AW-1:0] exp_add(int k);
        return 32'h1000_0000 + 32'(k * 4);
    endfunction

    function automatic logic [DW-1:0] exp_wdata(int k);
        return 32'hD000_0000 + 32'(k);
    endfunction

    function automatic int exp_win(logic [NB-1:0] r, int ptr);
`ifdef DMAC_ARB_FC_PRIO_EN
        if (r[NB-1]) return NB - 1;
`endif
        for (int i = 0; i < NB; i++) begin
            automatic int j = (ptr + i) % NB;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    function automatic int next_ptr(int w, int ptr);
`ifdef DMAC_ARB_FC_PRIO_EN
        if (w == NB - 1) return ptr;
`endif
        return (w + 1) % NB;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        req         = '0;
        tgt_gnt     = 1'b0;
        tgt_r_valid = 1'b0;
        tgt_r_rdata = '0;
        tgt_r_opc   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_ptr = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++;
        if (gnt !== '0 || tgt_req !== 1'b0 || r_valid !== '0) begin
            $display("FAIL reset_comb: gnt=%h tgt_req=%b r_valid=%h want 0", gnt, tgt_req, r_valid);
        end else pass_cnt++;
        total++;
        if (busy !== 1'b0 || resp_err !== 1'b0) begin
            $display("FAIL reset_state: busy=%b err=%b want 0 0", busy, resp_err);
        end else pass_cnt++;
        total++;
        if (tgt_add !== '0 || tgt_id !== '0 || r_rdata !== '0) begin
            $display("FAIL reset_payload: add=%h id=%0d rdata=%h want 0", tgt_add, tgt_id, r_rdata);
        end else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [NB-1:0] pat [3];
        int w;
        pat[0] = 10'h003;
        pat[1] = 10'h003;
        pat[2] = 10'h005;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            req     = pat[k];
            tgt_gnt = 1'b1;
            @(negedge clk);
            w = exp_win(req, m_ptr);
            total++;
            if (gnt !== 10'(1 << w) || tgt_id !== IW'(w)) begin
                $display("FAIL basic_gnt%0d: gnt=%h id=%0d want %h %0d", k, gnt, tgt_id, 10'(1 << w), w);
            end else pass_cnt++;
            total++;
            if (tgt_add !== exp_add(w) || tgt_wdata !== exp_wdata(w) || tgt_wen !== wen[w]) begin
                $display("FAIL basic_payload%0d: add=%h wdata=%h want %h %h", k, tgt_add, tgt_wdata, exp_add(w), exp_wdata(w));
            end else pass_cnt++;
            exp_q.push_back(w);
            m_ptr = next_ptr(w, m_ptr);
            tick();
        end
        req     = '0;
        tgt_gnt = 1'b0;
        while (exp_q.size() > 0) begin
            tgt_r_valid = 1'b1;
            tgt_r_rdata = $urandom;
            tgt_r_opc   = 1'($urandom_range(0, 1));
            @(negedge clk);
            total++;
            if (r_valid !== 10'(1 << exp_q[0]) || r_rdata !== tgt_r_rdata || r_opc !== tgt_r_opc) begin
                $display("FAIL basic_resp: r_valid=%h rdata=%h want %h %h", r_valid, r_rdata, 10'(1 << exp_q[0]), tgt_r_rdata);
            end else pass_cnt++;
            void'(exp_q.pop_front());
            tick();
        end
        tgt_r_valid = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || resp_err !== 1'b0) begin
            $display("FAIL basic_idle: busy=%b err=%b want 0 0", busy, resp_err);
        end else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int w;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            req         = (k < 11) ? '1 : '0;
            tgt_gnt     = 1'b1;
            tgt_r_valid = (k > 0);
            tgt_r_rdata = 32'(k);
            @(negedge clk);
            if (k > 0) begin
                total++;
                if (r_valid !== 10'(1 << exp_q[0])) begin
                    $display("FAIL b2b_resp%0d: r_valid=%h want %h", k, r_valid, 10'(1 << exp_q[0]));
                end else pass_cnt++;
                void'(exp_q.pop_front());
            end
            if (k < 11) begin
                w = exp_win(req, m_ptr);
                total++;
                if (gnt !== 10'(1 << w) || tgt_id !== IW'(w)) begin
                    $display("FAIL b2b_gnt%0d: gnt=%h id=%0d want %h %0d", k, gnt, tgt_id, 10'(1 << w), w);
                end else pass_cnt++;
                exp_q.push_back(w);
                m_ptr = next_ptr(w, m_ptr);
            end
            tick();
        end
        req         = '0;
        tgt_r_valid = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || resp_err !== 1'b0) begin
            $display("FAIL b2b_idle: busy=%b err=%b want 0 0", busy, resp_err);
        end else pass_cnt++;
    endtask

    task automatic test_full();
        int ids [4] = '{3, 5, 7, 9};
        int w;
        do_reset();
        foreach (ids[k]) begin
            req     = 10'(1 << ids[k]);
            tgt_gnt = 1'b1;
            @(negedge clk);
            w = exp_win(req, m_ptr);
            total++;
            if (gnt !== 10'(1 << w)) begin
                $display("FAIL full_fill%0d: gnt=%h want %h", k, gnt, 10'(1 << w));
            end else pass_cnt++;
            exp_q.push_back(w);
            m_ptr = next_ptr(w, m_ptr);
            tick();
        end
        req = 10'h002;
        @(negedge clk);
        total++;
        if (tgt_req !== (exp_q.size() < 4) || gnt !== '0 || busy !== 1'b1) begin
            $display("FAIL full_block: tgt_req=%b gnt=%h busy=%b want 0 0 1", tgt_req, gnt, busy);
        end else pass_cnt++;
        tick();
        tgt_r_valid = 1'b1;
        tgt_r_rdata = 32'hCAFE_0003;
        @(negedge clk);
        total++;
        if (r_valid !== 10'(1 << exp_q[0]) || gnt !== '0 || tgt_req !== 1'b0) begin
            $display("FAIL full_pop: r_valid=%h gnt=%h tgt_req=%b want %h 0 0", r_valid, gnt, tgt_req, 10'(1 << exp_q[0]));
        end else pass_cnt++;
        void'(exp_q.pop_front());
        tick();
        tgt_r_valid = 1'b0;
        @(negedge clk);
        w = exp_win(req, m_ptr);
        total++;
        if (gnt !== 10'(1 << w) || tgt_id !== IW'(w)) begin
            $display("FAIL full_regrant: gnt=%h id=%0d want %h %0d", gnt, tgt_id, 10'(1 << w), w);
        end else pass_cnt++;
        exp_q.push_back(w);
        m_ptr = next_ptr(w, m_ptr);
        tick();
        req     = '0;
        tgt_gnt = 1'b0;
        while (exp_q.size() > 0) begin
            tgt_r_valid = 1'b1;
            @(negedge clk);
            total++;
            if (r_valid !== 10'(1 << exp_q[0])) begin
                $display("FAIL full_drain: r_valid=%h want %h", r_valid, 10'(1 << exp_q[0]));
            end else pass_cnt++;
            void'(exp_q.pop_front());
            tick();
        end
        tgt_r_valid = 1'b0;
    endtask

    task automatic test_resp_err();
        do_reset();
        tgt_r_valid = 1'b1;
        tgt_r_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        total++;
        if (r_valid !== '0 || resp_err !== 1'b0) begin
            $display("FAIL err_drop: r_valid=%h err=%b want 0 0", r_valid, resp_err);
        end else pass_cnt++;
        tick();
        tgt_r_valid = 1'b0;
        req         = 10'h010;
        tgt_gnt     = 1'b1;
        @(negedge clk);
        total++;
        if (resp_err !== 1'b1 || gnt !== 10'h010) begin
            $display("FAIL err_set: err=%b gnt=%h want 1 010", resp_err, gnt);
        end else pass_cnt++;
        tick();
        req         = '0;
        tgt_gnt     = 1'b0;
        tgt_r_valid = 1'b1;
        @(negedge clk);
        total++;
        if (r_valid !== 10'h010) begin
            $display("FAIL err_resp: r_valid=%h want 010", r_valid);
        end else pass_cnt++;
        tick();
        tgt_r_valid = 1'b0;
        tick();
        @(negedge clk);
        total++;
        if (resp_err !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL err_sticky: err=%b busy=%b want 1 0", resp_err, busy);
        end else pass_cnt++;
        do_reset();
        @(negedge clk);
        total++;
        if (resp_err !== 1'b0) begin
            $display("FAIL err_clear: err=%b want 0", resp_err);
        end else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int w;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            req     = 10'h003;
            tgt_gnt = 1'b1;
            tick();
        end
        req = '0;
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            $display("FAIL mrst_busy: busy=%b want 1", busy);
        end else pass_cnt++;
        tick();
        rst = 1'b1;
        req = '1;
        @(negedge clk);
        total++;
        if (gnt !== '0 || tgt_req !== 1'b0) begin
            $display("FAIL mrst_gnt: gnt=%h tgt_req=%b want 0 0", gnt, tgt_req);
        end else pass_cnt++;
        tick();
        rst   = 1'b0;
        m_ptr = 0;
        exp_q.delete();
        @(negedge clk);
        w = exp_win(req, m_ptr);
        total++;
        if (busy !== 1'b0 || gnt !== 10'(1 << w)) begin
            $display("FAIL mrst_after: busy=%b gnt=%h want 0 %h", busy, gnt, 10'(1 << w));
        end else pass_cnt++;
        exp_q.push_back(w);
        tick();
        req         = '0;
        tgt_gnt     = 1'b0;
        tgt_r_valid = 1'b1;
        @(negedge clk);
        total++;
        if (r_valid !== 10'(1 << exp_q[0]) || resp_err !== 1'b0) begin
            $display("FAIL mrst_resp: r_valid=%h err=%b want %h 0", r_valid, resp_err, 10'(1 << exp_q[0]));
        end else pass_cnt++;
        void'(exp_q.pop_front());
        tick();
        tgt_r_valid = 1'b0;
    endtask

`ifdef DMAC_ARB_FC_PRIO_EN
    task automatic test_fc_prio();
        int w;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            req         = (k < 3) ? 10'h201 : (k == 3) ? 10'h001 : 10'h000;
            tgt_gnt     = 1'b1;
            tgt_r_valid = (k > 0);
            @(negedge clk);
            if (k > 0) begin
                total++;
                if (r_valid !== 10'(1 << exp_q[0])) begin
                    $display("FAIL fc_resp%0d: r_valid=%h want %h", k, r_valid, 10'(1 << exp_q[0]));
                end else pass_cnt++;
                void'(exp_q.pop_front());
            end
            if (k < 4) begin
                w = exp_win(req, m_ptr);
                total++;
                if (gnt !== 10'(1 << w)) begin
                    $display("FAIL fc_gnt%0d: gnt=%h want %h", k, gnt, 10'(1 << w));
                end else pass_cnt++;
                exp_q.push_back(w);
                m_ptr = next_ptr(w, m_ptr);
            end
            tick();
        end
        tgt_r_valid = 1'b0;
        tgt_gnt     = 1'b0;
    endtask
`endif

    initial begin
        for (int k = 0; k < NB; k++) begin
            add[k*AW +: AW]   = exp_add(k);
            wdata[k*DW +: DW] = exp_wdata(k);
            be[k*BW +: BW]    = 4'hF ^ 4'(k);
        end
        wen = 10'b01_0101_0101;
        test_reset();
        test_basic();
        test_back_to_back();
        test_full();
        test_resp_err();
        test_mid_reset();
`ifdef DMAC_ARB_FC_PRIO_EN
        test_fc_prio();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
